l74x194_scan: RTL and testbench
===============================

// Module: l74x194_scan
// PURPOSE
//  Parametrised successor to our 74-series gate models: a WIDTH-bit universal shift register
//  (74x194 modes: hold / shift up / shift down / parallel load) with a built-in step prescaler
//  and an auto "bounce" mode that sweeps a pattern end-to-end and reverses (Larson scan).
//  Drives the LED bank directly; replaces the discrete counter/decoder/NOR steering chain.
// PARAMETERS
//  WIDTH      8            register width, >=2
//  DIV        1            enabled clocks per shift step, >=1 (1 = every enabled clock)
//  RESET_VAL  WIDTH'(1)    o_q value after reset
// PORTS
//  i_clk    in   1      clock, all state updates on rising edge
//  i_rst_n  in   1      reset, synchronous, active-low; one clock, sync reset active-low
//  i_en     in   1      clock enable; low freezes all state incl. prescaler
//  i_s      in   2      mode: 00 hold, 01 shift up, 10 shift down, 11 parallel load
//  i_auto   in   1      1 = bounce mode (overrides i_s 00/01/10; load still wins)
//  i_dsu    in   1      serial in for shift up (enters bit 0)
//  i_dsd    in   1      serial in for shift down (enters bit WIDTH-1)
//  i_d      in   WIDTH  parallel load data
//  o_q      out  WIDTH  register contents
//  o_dir    out  1      bounce direction state: 0 UP (toward MSB), 1 DOWN
//  o_step   out  1      registered pulse: 1 the cycle after o_q took a shift/bounce step
//  o_end    out  1      registered pulse: 1 the cycle after a bounce reversal
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge) wins over everything: o_q=RESET_VAL, dir=UP, prescaler cnt=0,
//    o_step=0, o_end=0. Reset mid-operation discards count and direction.
//  - i_en=0: o_q, dir, cnt hold; o_step=0, o_end=0 at next edge.
//  - Prescaler: cnt 0..DIV-1, width max(1,$clog2(DIV)); tick = i_en && cnt==DIV-1 (comb);
//    cnt increments on each enabled clock, wraps to 0 on tick.
//  - Load (i_s=11, i_en=1): o_q<=i_d on that edge, independent of tick, in manual or auto;
//    cnt<=0; dir unchanged; o_step=0. Next step occurs DIV enabled clocks later.
//  - Manual (i_auto=0), on tick only: 00 hold (o_step=0); 01 o_q<={o_q[W-2:0],i_dsu};
//    10 o_q<={i_dsd,o_q[W-1:1]}; o_step=1 for 01/10. Manual shifts never change dir.
//  - Auto (i_auto=1, i_s!=11), on tick, FSM UP/DOWN, serial in always 0:
//    UP:   o_q[W-1]=0 -> shift up; o_q[W-1]=1 -> dir<=DOWN, shift down same tick, o_end=1.
//    DOWN: o_q[0]=0 -> shift down; o_q[0]=1 -> dir<=UP, shift up same tick, o_end=1.
//    Only the end in the current direction is checked (bits at the far end may be lost).
//    o_q==0 on tick -> o_q<=WIDTH'(1), dir<=UP, o_end=0. o_step=1 on every auto tick.
//  - No dwell at ends: W=8 one-hot sweep period is 2*(W-1)=14 steps.
//  - Latency: o_q updates at the tick edge; o_step/o_end one cycle later, one cycle wide.
// STRUCTURE
//  - Package l74_pkg: typedef enum logic [1:0] l74_mode_e {M_HOLD,M_UP,M_DOWN,M_LOAD};
//    typedef enum logic {DIR_UP,DIR_DOWN} l74_dir_e.
//  - Sub-module l74_prescaler #(DIV): i_clk,i_rst_n,i_en,i_clr -> o_tick (clr from load).
//  - Top holds register, direction FSM and output pulse flops.
// TESTING
//  1 Reset: W=8,DIV=1, i_rst_n=0 2 clocks -> o_q=8'h01, o_dir=0, o_step=0, o_end=0.
//  2 Manual: load 8'hA5; s=01,dsu=1 -> 8'h4B, o_step=1 next cycle; s=10,dsd=0 -> 8'h25;
//    s=00 -> holds 8'h25, o_step=0.
//  3 Bounce DIV=1 from 8'h01: steps 02,04..80 (7), then 40 with o_dir=1 and o_end pulse,
//    ..01 at step 14, step 15 -> 02 with o_dir=0 and o_end pulse.
//  4 DIV=3: o_q steps every 3rd enabled clock; i_en=0 for 5 clocks at cnt=1 freezes;
//    load 8'h10 at cnt=2 -> next step exactly 3 enabled clocks later.
//  5 Auto with load 8'h00 -> next tick o_q=8'h01, o_dir=0, o_end=0.
//  6 Reset while DOWN, DIV=3, cnt=2 -> o_q=RESET_VAL, o_dir=0, next step after 3 clocks.

Source files
------------

// File: rtl/l74_pkg.sv
// Shared types and helpers for the 74x194-style scan register.
package l74_pkg;

  typedef enum logic [1:0] {M_HOLD, M_UP, M_DOWN, M_LOAD} l74_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} l74_dir_e;

  // Prescaler counter width; a divide-by-one still needs a one-bit counter.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/l74_prescaler.sv
// Step prescaler: o_tick is high on the enabled clock that completes a DIV-clock period.
module l74_prescaler
  import l74_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign o_tick = i_en && (cnt_reg == CNT_LAST);

  // A clear (parallel load) restarts the period so the next step is DIV enabled clocks away.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (i_en) begin
      if (i_clr || o_tick) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/l74x194_scan.sv
// WIDTH-bit universal shift register with step prescaler and auto bounce (Larson scan) mode.
module l74x194_scan
  import l74_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DIV       = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_s,
  input  logic             i_auto,
  input  logic             i_dsu,
  input  logic             i_dsd,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_end
);

  l74_mode_e        mode;
  logic             tick;
  logic             is_load;
  logic [WIDTH-1:0] q_reg;
  l74_dir_e         dir_reg;
  logic             step_reg;
  logic             end_reg;
  logic [WIDTH-1:0] up_q;
  logic [WIDTH-1:0] down_q;

  assign mode    = l74_mode_e'(i_s);
  assign is_load = (mode == M_LOAD);

  // Bounce mode always shifts in zeros; manual mode uses the serial inputs.
  assign up_q   = {q_reg[WIDTH-2:0], (i_auto ? 1'b0 : i_dsu)};
  assign down_q = {(i_auto ? 1'b0 : i_dsd), q_reg[WIDTH-1:1]};

  l74_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_clr   (is_load),
    .o_tick  (tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      q_reg    <= RESET_VAL;
      dir_reg  <= DIR_UP;
      step_reg <= 1'b0;
      end_reg  <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      end_reg  <= 1'b0;
      if (i_en) begin
        if (is_load) begin
          q_reg <= i_d;
        end else if (tick && i_auto) begin
          step_reg <= 1'b1;
          if (q_reg == '0) begin
            // Empty register would sweep forever as zeros; reseed a single lit bit.
            q_reg   <= WIDTH'(1);
            dir_reg <= DIR_UP;
          end else if (dir_reg == DIR_UP) begin
            if (q_reg[WIDTH-1]) begin
              q_reg   <= down_q;
              dir_reg <= DIR_DOWN;
              end_reg <= 1'b1;
            end else begin
              q_reg <= up_q;
            end
          end else begin
            if (q_reg[0]) begin
              q_reg   <= up_q;
              dir_reg <= DIR_UP;
              end_reg <= 1'b1;
            end else begin
              q_reg <= down_q;
            end
          end
        end else if (tick) begin
          case (mode)
            M_UP: begin
              q_reg    <= up_q;
              step_reg <= 1'b1;
            end
            M_DOWN: begin
              q_reg    <= down_q;
              step_reg <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_q    = q_reg;
  assign o_dir  = (dir_reg == DIR_DOWN);
  assign o_step = step_reg;
  assign o_end  = end_reg;

endmodule

// File: tb/tb_l74x194_scan.sv
// Directed-vector bench for l74x194_scan: one DIV=1 and one DIV=3 instance on shared inputs.
module tb_l74x194_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] s = 2'b00;
  logic       auto_md = 1'b0;
  logic       dsu = 1'b0;
  logic       dsd = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q1, q3;
  logic       dir1, dir3, step1, step3, end1, end3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  l74x194_scan #(.WIDTH(8), .DIV(1), .RESET_VAL(8'h01)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_s(s), .i_auto(auto_md),
    .i_dsu(dsu), .i_dsd(dsd), .i_d(d),
    .o_q(q1), .o_dir(dir1), .o_step(step1), .o_end(end1)
  );

  l74x194_scan #(.WIDTH(8), .DIV(3), .RESET_VAL(8'h01)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_s(s), .i_auto(auto_md),
    .i_dsu(dsu), .i_dsd(dsd), .i_d(d),
    .o_q(q3), .o_dir(dir3), .o_step(step3), .o_end(end3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounce sweep from 8'h01 with DIV=1: q, dir and end pulse after each step.
  logic [7:0] sweep_q   [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic       sweep_dir [15] = '{0,0,0,0,0,0,0, 1,1,1,1,1,1,1, 0};
  logic       sweep_end [15] = '{0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 1};

  initial begin
    // 1: reset
    cyc(); cyc();
    chk("rst_q", q1, 8'h01);
    chk("rst_dir", {7'd0, dir1}, 8'h00);
    chk("rst_step", {7'd0, step1}, 8'h00);
    chk("rst_end", {7'd0, end1}, 8'h00);
    chk("rst_q3", q3, 8'h01);

    // 2: manual modes on DIV=1
    rst_n = 1'b1; en = 1'b1;
    s = 2'b11; d = 8'hA5; cyc();
    chk("load_q", q1, 8'hA5);
    chk("load_step", {7'd0, step1}, 8'h00);
    s = 2'b01; dsu = 1'b1; cyc();
    chk("up_q", q1, 8'h4B);
    chk("up_step", {7'd0, step1}, 8'h01);
    s = 2'b10; dsd = 1'b0; cyc();
    chk("dn_q", q1, 8'h25);
    chk("dn_step", {7'd0, step1}, 8'h01);
    chk("dn_dir", {7'd0, dir1}, 8'h00);
    s = 2'b00; cyc();
    chk("hold_q", q1, 8'h25);
    chk("hold_step", {7'd0, step1}, 8'h00);

    // 3: bounce sweep, DIV=1
    auto_md = 1'b1; s = 2'b11; d = 8'h01; cyc();
    chk("bload_q", q1, 8'h01);
    s = 2'b00;
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("sweep%0d_q", i + 1), q1, sweep_q[i]);
      chk($sformatf("sweep%0d_dir", i + 1), {7'd0, dir1}, {7'd0, sweep_dir[i]});
      chk($sformatf("sweep%0d_end", i + 1), {7'd0, end1}, {7'd0, sweep_end[i]});
      chk($sformatf("sweep%0d_step", i + 1), {7'd0, step1}, 8'h01);
    end
    cyc();
    chk("sweep_end_width", {7'd0, end1}, 8'h00);

    // 4: DIV=3 prescaler, freeze, load restart
    auto_md = 1'b0; rst_n = 1'b0; cyc();
    rst_n = 1'b1; s = 2'b01; dsu = 1'b0;
    cyc(); chk("p_c1_q", q3, 8'h01); chk("p_c1_step", {7'd0, step3}, 8'h00);
    cyc(); chk("p_c2_q", q3, 8'h01);
    cyc(); chk("p_c3_q", q3, 8'h02); chk("p_c3_step", {7'd0, step3}, 8'h01);
    cyc(); chk("p_c4_step", {7'd0, step3}, 8'h00);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("frz%0d_q", i), q3, 8'h02);
      chk($sformatf("frz%0d_step", i), {7'd0, step3}, 8'h00);
    end
    en = 1'b1;
    cyc(); chk("p_c5_q", q3, 8'h02);
    cyc(); chk("p_c6_q", q3, 8'h04); chk("p_c6_step", {7'd0, step3}, 8'h01);
    cyc(); cyc();
    s = 2'b11; d = 8'h10; cyc();
    chk("p_load_q", q3, 8'h10); chk("p_load_step", {7'd0, step3}, 8'h00);
    s = 2'b01;
    cyc(); chk("p_l1_q", q3, 8'h10);
    cyc(); chk("p_l2_q", q3, 8'h10);
    cyc(); chk("p_l3_q", q3, 8'h20); chk("p_l3_step", {7'd0, step3}, 8'h01);

    // 5: auto with zero load reseeds (from DOWN), DIV=1
    auto_md = 1'b1; s = 2'b11; d = 8'h80; cyc();
    s = 2'b00; cyc();
    chk("z_pre_q", q1, 8'h40); chk("z_pre_dir", {7'd0, dir1}, 8'h01);
    s = 2'b11; d = 8'h00; cyc();
    chk("z_load_q", q1, 8'h00);
    s = 2'b00; cyc();
    chk("z_q", q1, 8'h01);
    chk("z_dir", {7'd0, dir1}, 8'h00);
    chk("z_end", {7'd0, end1}, 8'h00);
    chk("z_step", {7'd0, step1}, 8'h01);

    // 6: reset while DOWN with cnt=2, DIV=3
    s = 2'b11; d = 8'h80; cyc();
    s = 2'b00; cyc(); cyc(); cyc();
    chk("r6_q", q3, 8'h40); chk("r6_dir", {7'd0, dir3}, 8'h01);
    chk("r6_end", {7'd0, end3}, 8'h01);
    cyc(); cyc();
    rst_n = 1'b0; cyc();
    chk("r6_rst_q", q3, 8'h01); chk("r6_rst_dir", {7'd0, dir3}, 8'h00);
    rst_n = 1'b1;
    cyc(); chk("r6_c1_q", q3, 8'h01);
    cyc(); chk("r6_c2_q", q3, 8'h01);
    cyc(); chk("r6_c3_q", q3, 8'h02); chk("r6_c3_step", {7'd0, step3}, 8'h01);
    chk("r6_c3_dir", {7'd0, dir3}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
